// File: rtl/trace_packer.sv
// Trace-side packer/unpacker between parallel trace lanes and the trace logger word interface.
// Optional macro TRACE_PACKER_PREFETCH_EN adds a one-word prefetch buffer for gap-free streaming.
`timescale 1ns/1ps

module trace_packer #(
    parameter int WIDTH       = 32,
    parameter int NTRACE_BITS = 3
) (
    input  logic                     CLK_I,
    input  logic                     RST_NI,
    input  logic                     MODE_I,
    input  logic [NTRACE_BITS-1:0]   NTRACE_I,
    input  logic [WIDTH-1:0]         TRACE_I,
    input  logic                     TRACE_VALID_I,
    input  logic                     TRG_I,
    input  logic                     TRG_DELAYED_I,
    output logic [WIDTH-1:0]         DATA_O,
    output logic                     STORE_O,
    input  logic                     STORE_PERM_I,
    output logic [$clog2(WIDTH)-1:0] EVENT_POS_O,
    output logic                     TRG_EVENT_O,
    output logic                     OVERFLOW_O,
    input  logic [WIDTH-1:0]         DATA_I,
    output logic                     LOAD_REQUEST_O,
    input  logic                     LOAD_GRANT_I,
    output logic [WIDTH-1:0]         STREAM_O,
    output logic                     STREAM_VALID_O,
    input  logic                     STREAM_READY_I
);

    localparam int LOG_W   = $clog2(WIDTH);
    localparam int LW_BITS = $clog2(LOG_W + 1);

    typedef enum logic [2:0] {
        CAPTURE,
        STOPPED,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t               state_reg, state_next;
    logic [LOG_W-1:0]     cnt_reg, cnt_next;
    logic [LW_BITS-1:0]   lane_log_reg, lane_log_next;
    logic [WIDTH-1:0]     shift_reg, shift_next;
    logic [WIDTH-1:0]     data_reg, data_next;
    logic                 store_reg, store_next;
    logic [LOG_W-1:0]     event_pos_reg, event_pos_next;
    logic                 trg_event_reg, trg_event_next;
    logic                 overflow_reg, overflow_next;

`ifdef TRACE_PACKER_PREFETCH_EN
    logic [WIDTH-1:0]     buf_reg, buf_next;
    logic                 buf_full_reg, buf_full_next;
    logic                 pf_issue_reg, pf_issue_next;
    logic                 pf_wait_reg, pf_wait_next;
`endif

    // Lane masks indexed by log2 of the lane count: entry gi has 2**gi low ones.
    logic [WIDTH-1:0] mask_tab [LOG_W+1];
    generate
        for (genvar gi = 0; gi <= LOG_W; gi++) begin : g_mask
            assign mask_tab[gi] = {WIDTH{1'b1}} >> (WIDTH - (2 ** gi));
        end
    endgenerate

    logic [LW_BITS-1:0] ntrace_clamp;
    logic [LW_BITS-1:0] lane_eff;
    logic [LOG_W:0]     lane_len;
    logic [LOG_W:0]     fill_sum;
    logic               lane_done;
    logic [WIDTH-1:0]   lane_mask;
    logic [WIDTH-1:0]   shift_pack;
    logic               stream_state;
    logic               mode_mismatch;

    assign ntrace_clamp = (int'(NTRACE_I) > LOG_W) ? LW_BITS'(LOG_W) : LW_BITS'(NTRACE_I);

    // A new lane count is only taken at a word boundary; draining always uses the latched value
    // so STREAM_O cannot change under a stalled handshake.
    assign lane_eff  = (cnt_reg == '0 && state_reg != S_DRAIN) ? ntrace_clamp : lane_log_reg;
    assign lane_len  = (LOG_W + 1)'(1) << lane_eff;
    assign fill_sum  = {1'b0, cnt_reg} + lane_len;
    assign lane_done = (fill_sum == (LOG_W + 1)'(WIDTH));
    assign lane_mask = mask_tab[lane_eff];

    assign shift_pack = (shift_reg & ~(lane_mask << cnt_reg)) | ((TRACE_I & lane_mask) << cnt_reg);

    assign stream_state  = (state_reg == S_REQ) || (state_reg == S_WAIT) || (state_reg == S_DRAIN);
    assign mode_mismatch = (MODE_I != stream_state);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        lane_log_next  = lane_eff;
        shift_next     = shift_reg;
        data_next      = data_reg;
        store_next     = 1'b0;
        event_pos_next = event_pos_reg;
        trg_event_next = trg_event_reg;
        overflow_next  = overflow_reg;
`ifdef TRACE_PACKER_PREFETCH_EN
        buf_next       = buf_reg;
        buf_full_next  = buf_full_reg;
        pf_issue_next  = pf_issue_reg;
        pf_wait_next   = pf_wait_reg;
`endif

        if (mode_mismatch) begin
            state_next     = MODE_I ? S_REQ : CAPTURE;
            cnt_next       = '0;
            shift_next     = '0;
            trg_event_next = 1'b0;
            overflow_next  = 1'b0;
            event_pos_next = '0;
`ifdef TRACE_PACKER_PREFETCH_EN
            buf_full_next  = 1'b0;
            pf_issue_next  = 1'b0;
            pf_wait_next   = 1'b0;
`endif
        end else begin
            case (state_reg)
                CAPTURE: begin
                    if (TRACE_VALID_I) begin
                        shift_next = shift_pack;
                        cnt_next   = fill_sum[LOG_W-1:0];
                        if (TRG_I && !trg_event_reg) begin
                            event_pos_next = cnt_reg;
                            trg_event_next = 1'b1;
                        end
                        if (lane_done) begin
                            data_next  = shift_pack;
                            store_next = STORE_PERM_I;
                            if (!STORE_PERM_I)
                                overflow_next = 1'b1;
                        end
                    end
                    // Stopping discards the partial word, but a word completed this beat is kept.
                    if (TRG_DELAYED_I) begin
                        state_next = STOPPED;
                        cnt_next   = '0;
                        shift_next = '0;
                    end
                end
                STOPPED: begin
                end
                S_REQ: begin
                    state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (LOAD_GRANT_I) begin
                        shift_next = DATA_I;
                        cnt_next   = '0;
                        state_next = S_DRAIN;
`ifdef TRACE_PACKER_PREFETCH_EN
                        pf_issue_next = 1'b1;
                        pf_wait_next  = 1'b0;
`endif
                    end
                end
                S_DRAIN: begin
`ifdef TRACE_PACKER_PREFETCH_EN
                    if (pf_issue_reg) begin
                        pf_issue_next = 1'b0;
                        pf_wait_next  = 1'b1;
                    end
                    if (pf_wait_reg && LOAD_GRANT_I) begin
                        buf_next      = DATA_I;
                        buf_full_next = 1'b1;
                        pf_wait_next  = 1'b0;
                    end
`endif
                    if (STREAM_READY_I) begin
                        cnt_next = fill_sum[LOG_W-1:0];
                        if (lane_done) begin
                            cnt_next = '0;
`ifdef TRACE_PACKER_PREFETCH_EN
                            // Refill shift without a bubble from the buffer or from a grant landing now.
                            if (buf_full_reg) begin
                                shift_next    = buf_reg;
                                buf_full_next = 1'b0;
                                pf_issue_next = 1'b1;
                                lane_log_next = ntrace_clamp;
                            end else if (pf_wait_reg && LOAD_GRANT_I) begin
                                shift_next    = DATA_I;
                                buf_full_next = 1'b0;
                                pf_issue_next = 1'b1;
                                lane_log_next = ntrace_clamp;
                            end else if (pf_wait_reg || pf_issue_reg) begin
                                state_next    = S_WAIT;
                                pf_issue_next = 1'b0;
                                pf_wait_next  = 1'b1;
                            end else begin
                                state_next = S_REQ;
                            end
`else
                            state_next = S_REQ;
`endif
                        end
                    end
                end
                default: begin
                    state_next = CAPTURE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_reg     <= CAPTURE;
            cnt_reg       <= '0;
            lane_log_reg  <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            store_reg     <= 1'b0;
            event_pos_reg <= '0;
            trg_event_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            lane_log_reg  <= lane_log_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            store_reg     <= store_next;
            event_pos_reg <= event_pos_next;
            trg_event_reg <= trg_event_next;
            overflow_reg  <= overflow_next;
        end
    end

`ifdef TRACE_PACKER_PREFETCH_EN
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            buf_reg      <= '0;
            buf_full_reg <= 1'b0;
            pf_issue_reg <= 1'b0;
            pf_wait_reg  <= 1'b0;
        end else begin
            buf_reg      <= buf_next;
            buf_full_reg <= buf_full_next;
            pf_issue_reg <= pf_issue_next;
            pf_wait_reg  <= pf_wait_next;
        end
    end

    assign LOAD_REQUEST_O = (state_reg == S_REQ) || (state_reg == S_DRAIN && pf_issue_reg);
`else
    assign LOAD_REQUEST_O = (state_reg == S_REQ);
`endif

    assign STREAM_VALID_O = (state_reg == S_DRAIN);
    assign STREAM_O       = STREAM_VALID_O ? ((shift_reg >> cnt_reg) & lane_mask) : '0;

    assign DATA_O      = data_reg;
    assign STORE_O     = store_reg;
    assign EVENT_POS_O = event_pos_reg;
    assign TRG_EVENT_O = trg_event_reg;
    assign OVERFLOW_O  = overflow_reg;

endmodule

// File: tb/tb_trace_packer.sv
// Directed bench for trace_packer: capture packing, trigger, overflow, clamp, stop, streaming, async reset.
`timescale 1ns/1ps

module tb_trace_packer;

    logic        CLK_I;
    logic        RST_NI;
    logic        MODE_I;
    logic [2:0]  NTRACE_I;
    logic [31:0] TRACE_I;
    logic        TRACE_VALID_I;
    logic        TRG_I;
    logic        TRG_DELAYED_I;
    logic [31:0] DATA_O;
    logic        STORE_O;
    logic        STORE_PERM_I;
    logic [4:0]  EVENT_POS_O;
    logic        TRG_EVENT_O;
    logic        OVERFLOW_O;
    logic [31:0] DATA_I;
    logic        LOAD_REQUEST_O;
    logic        LOAD_GRANT_I;
    logic [31:0] STREAM_O;
    logic        STREAM_VALID_O;
    logic        STREAM_READY_I;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    trace_packer #(.WIDTH(32), .NTRACE_BITS(3)) dut (
        .CLK_I          (CLK_I),
        .RST_NI         (RST_NI),
        .MODE_I         (MODE_I),
        .NTRACE_I       (NTRACE_I),
        .TRACE_I        (TRACE_I),
        .TRACE_VALID_I  (TRACE_VALID_I),
        .TRG_I          (TRG_I),
        .TRG_DELAYED_I  (TRG_DELAYED_I),
        .DATA_O         (DATA_O),
        .STORE_O        (STORE_O),
        .STORE_PERM_I   (STORE_PERM_I),
        .EVENT_POS_O    (EVENT_POS_O),
        .TRG_EVENT_O    (TRG_EVENT_O),
        .OVERFLOW_O     (OVERFLOW_O),
        .DATA_I         (DATA_I),
        .LOAD_REQUEST_O (LOAD_REQUEST_O),
        .LOAD_GRANT_I   (LOAD_GRANT_I),
        .STREAM_O       (STREAM_O),
        .STREAM_VALID_O (STREAM_VALID_O),
        .STREAM_READY_I (STREAM_READY_I)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %s observed=%08h expected=%08h ok", tag, obs, exp);
        end else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic beat(input logic [31:0] v);
        TRACE_VALID_I = 1'b1;
        TRACE_I       = v;
        tick();
    endtask

    initial begin
        RST_NI = 1'b0; MODE_I = 1'b0; NTRACE_I = 3'd3; TRACE_I = '0; TRACE_VALID_I = 1'b0;
        TRG_I = 1'b0; TRG_DELAYED_I = 1'b0; STORE_PERM_I = 1'b1; DATA_I = '0;
        LOAD_GRANT_I = 1'b0; STREAM_READY_I = 1'b0;

        // reset state
        tick(); tick();
        check("rst_data", DATA_O, 32'h0);
        check("rst_store", {31'h0, STORE_O}, 32'h0);
        check("rst_trg", {31'h0, TRG_EVENT_O}, 32'h0);
        check("rst_ovf", {31'h0, OVERFLOW_O}, 32'h0);
        check("rst_req", {31'h0, LOAD_REQUEST_O}, 32'h0);
        check("rst_svalid", {31'h0, STREAM_VALID_O}, 32'h0);
        check("rst_evpos", {27'h0, EVENT_POS_O}, 32'h0);
        RST_NI = 1'b1;

        // 8-bit lanes, four beats per word
        NTRACE_I = 3'd3;
        beat(32'h11); beat(32'h22); beat(32'h33);
        check("pk8_nostore", {31'h0, STORE_O}, 32'h0);
        beat(32'h44);
        check("pk8_data", DATA_O, 32'h44332211);
        check("pk8_store", {31'h0, STORE_O}, 32'h1);
        TRACE_VALID_I = 1'b0;
        tick();
        check("pk8_store_once", {31'h0, STORE_O}, 32'h0);

        // 4-bit lanes with upper garbage, trigger on third beat then again on fifth
        NTRACE_I = 3'd2;
        beat(32'hABCDE001); beat(32'hABCDE002);
        TRG_I = 1'b1; beat(32'hABCDE003); TRG_I = 1'b0;
        check("trg_pos", {27'h0, EVENT_POS_O}, 32'd8);
        check("trg_flag", {31'h0, TRG_EVENT_O}, 32'h1);
        beat(32'hABCDE004);
        TRG_I = 1'b1; beat(32'hABCDE005); TRG_I = 1'b0;
        beat(32'hABCDE006); beat(32'hABCDE007); beat(32'hABCDE008);
        check("trg_pos_kept", {27'h0, EVENT_POS_O}, 32'd8);
        check("pk4_data", DATA_O, 32'h87654321);
        check("pk4_store", {31'h0, STORE_O}, 32'h1);
        TRACE_VALID_I = 1'b0;
        tick();

        // dropped word then a normal word
        NTRACE_I = 3'd3;
        beat(32'hA1); beat(32'hA2); beat(32'hA3);
        STORE_PERM_I = 1'b0; beat(32'hA4);
        check("ovf_store", {31'h0, STORE_O}, 32'h0);
        check("ovf_flag", {31'h0, OVERFLOW_O}, 32'h1);
        STORE_PERM_I = 1'b1;
        beat(32'hB1); beat(32'hB2); beat(32'hB3); beat(32'hB4);
        check("ovf_next_data", DATA_O, 32'hB4B3B2B1);
        check("ovf_next_store", {31'h0, STORE_O}, 32'h1);
        check("ovf_sticky", {31'h0, OVERFLOW_O}, 32'h1);
        TRACE_VALID_I = 1'b0;
        tick();

        // NTRACE clamped to full width: one store per beat
        NTRACE_I = 3'd7;
        beat(32'h12345678);
        check("full_data0", DATA_O, 32'h12345678);
        check("full_store0", {31'h0, STORE_O}, 32'h1);
        beat(32'hCAFEF00D);
        check("full_data1", DATA_O, 32'hCAFEF00D);
        check("full_store1", {31'h0, STORE_O}, 32'h1);
        TRACE_VALID_I = 1'b0;
        tick();
        check("full_idle", {31'h0, STORE_O}, 32'h0);

        // trigger delay expires on a completing beat: stored, then stopped
        NTRACE_I = 3'd3;
        beat(32'h01); beat(32'h02); beat(32'h03);
        TRG_DELAYED_I = 1'b1; beat(32'h04); TRG_DELAYED_I = 1'b0;
        check("stop_data", DATA_O, 32'h04030201);
        check("stop_store", {31'h0, STORE_O}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            beat(32'hEE);
            check("stopped_nostore", {31'h0, STORE_O}, 32'h0);
        end
        TRACE_VALID_I = 1'b0;

        // switch to streaming, 16-bit lanes
        MODE_I = 1'b1; NTRACE_I = 3'd4;
        tick();
        check("s_req", {31'h0, LOAD_REQUEST_O}, 32'h1);
        check("mode_clr_trg", {31'h0, TRG_EVENT_O}, 32'h0);
        check("mode_clr_ovf", {31'h0, OVERFLOW_O}, 32'h0);
        tick();
        check("s_wait_req", {31'h0, LOAD_REQUEST_O}, 32'h0);
        check("s_wait_valid", {31'h0, STREAM_VALID_O}, 32'h0);
        LOAD_GRANT_I = 1'b1; DATA_I = 32'hDEADBEEF;
        tick();
        LOAD_GRANT_I = 1'b0;
        check("s_lo", STREAM_O, 32'h0000BEEF);
        check("s_lo_valid", {31'h0, STREAM_VALID_O}, 32'h1);
`ifdef TRACE_PACKER_PREFETCH_EN
        check("pf_req", {31'h0, LOAD_REQUEST_O}, 32'h1);
`else
        check("drain_noreq", {31'h0, LOAD_REQUEST_O}, 32'h0);
`endif
        tick();
        check("s_stall", STREAM_O, 32'h0000BEEF);
        LOAD_GRANT_I = 1'b1; DATA_I = 32'h01234567;
        tick();
        LOAD_GRANT_I = 1'b0; DATA_I = '0;
        check("s_stall2", STREAM_O, 32'h0000BEEF);
        STREAM_READY_I = 1'b1;
        tick();
        check("s_hi", STREAM_O, 32'h0000DEAD);
        tick();
`ifdef TRACE_PACKER_PREFETCH_EN
        check("pf_nogap_valid", {31'h0, STREAM_VALID_O}, 32'h1);
        check("pf_next_lo", STREAM_O, 32'h00004567);
        check("pf_next_req", {31'h0, LOAD_REQUEST_O}, 32'h1);
        tick();
        check("pf_next_hi", STREAM_O, 32'h00000123);
`else
        check("s_gap_valid", {31'h0, STREAM_VALID_O}, 32'h0);
        check("s_rereq", {31'h0, LOAD_REQUEST_O}, 32'h1);
        tick();
        LOAD_GRANT_I = 1'b1; DATA_I = 32'h01234567;
        tick();
        LOAD_GRANT_I = 1'b0; DATA_I = '0;
        check("s_next_lo", STREAM_O, 32'h00004567);
        check("s_next_valid", {31'h0, STREAM_VALID_O}, 32'h1);
`endif
        STREAM_READY_I = 1'b0;

        // back to capture, partial word, then asynchronous reset between edges
        MODE_I = 1'b0; NTRACE_I = 3'd3;
        tick();
        check("cap_svalid", {31'h0, STREAM_VALID_O}, 32'h0);
        beat(32'h55);
        TRG_I = 1'b1; beat(32'h66); TRG_I = 1'b0;
        TRACE_VALID_I = 1'b0;
        check("pre_rst_trg", {31'h0, TRG_EVENT_O}, 32'h1);
        check("pre_rst_pos", {27'h0, EVENT_POS_O}, 32'd8);
        #2 RST_NI = 1'b0;
        #1;
        check("arst_trg", {31'h0, TRG_EVENT_O}, 32'h0);
        check("arst_pos", {27'h0, EVENT_POS_O}, 32'h0);
        check("arst_data", DATA_O, 32'h0);
        check("arst_store", {31'h0, STORE_O}, 32'h0);
        #2 RST_NI = 1'b1;
        beat(32'h77); beat(32'h88); beat(32'h99); beat(32'hAA);
        check("post_rst_data", DATA_O, 32'hAA998877);
        check("post_rst_store", {31'h0, STORE_O}, 32'h1);
        TRACE_VALID_I = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/trace_packer.md
Name: trace_packer

Overview:
- Tracer-side stage that feeds the trace logger.
- Trace mode: packs 2**n parallel trace lanes per valid beat into WIDTH-bit words, hands each full word to the logger via DATA_O/STORE_O, and reports the bit position of the trigger.
- Stream mode: requests words from the logger and unpacks them onto the lane outputs.

Parameters:
- WIDTH, 32, memory word width in bits; power of two, at least 2.
- NTRACE_BITS, 3, width of the NTRACE_I field.

Ports:
- CLK_I  in  1  clock
- RST_NI  in  1  reset; asynchronous, active-low
- MODE_I  in  1  0 = trace-buffer mode, 1 = data-streaming mode
- NTRACE_I  in  NTRACE_BITS  log2 of the lane count
- TRACE_I  in  WIDTH  lane data; low L bits used
- TRACE_VALID_I  in  1  capture beat qualifier
- TRG_I  in  1  trigger condition
- TRG_DELAYED_I  in  1  trigger delay expired; stop capture
- DATA_O  out  WIDTH  packed word to logger
- STORE_O  out  1  one-cycle store strobe
- STORE_PERM_I  in  1  logger accepts a store
- EVENT_POS_O  out  $clog2(WIDTH)  bit position of the trigger beat within its word
- TRG_EVENT_O  out  1  sticky trigger flag
- OVERFLOW_O  out  1  sticky: a completed word was dropped
- DATA_I  in  WIDTH  word from logger
- LOAD_REQUEST_O  out  1  one-cycle read request
- LOAD_GRANT_I  in  1  DATA_I valid this cycle
- STREAM_O  out  WIDTH  unpacked lanes, low L bits valid
- STREAM_VALID_O  out  1  STREAM_O valid
- STREAM_READY_I  in  1  consumer accepts STREAM_O

Behaviour:
- Reset: all outputs 0, fill counter 0, state CAPTURE.
- Lane count: L = 2**min(NTRACE_I, log2(WIDTH)).
  - NTRACE_I is latched only when the fill/drain counter is 0; changes mid-word take effect at the next word.
- States: CAPTURE, STOPPED, S_REQ, S_WAIT, S_DRAIN.
- Mode select: MODE_I is compared every cycle. On a mismatch, the next state is CAPTURE (MODE_I=0) or S_REQ (MODE_I=1), the counter clears, and any partial word is discarded.
- CAPTURE, per beat with TRACE_VALID_I=1:
  - TRACE_I[L-1:0] is written to shift[fill+L-1:fill]; fill += L, modulo WIDTH.
  - On the beat where fill+L == WIDTH, at the same edge:
    - DATA_O <= completed word;
    - STORE_O <= STORE_PERM_I;
    - if STORE_PERM_I=0, the word is dropped and OVERFLOW_O <= 1.
  - STORE_O latency is one cycle after the completing beat; STORE_O is never high two cycles in a row unless L == WIDTH.
- Trigger:
  - Captured on the first valid beat with TRG_I=1 while TRG_EVENT_O=0: EVENT_POS_O <= fill (pre-increment) and TRG_EVENT_O <= 1.
  - Further triggers are ignored.
  - A trigger on a word-completing beat reports that beat's fill.
- TRG_DELAYED_I=1 in CAPTURE:
  - go to STOPPED and discard the partial word;
  - a word completing in the same cycle is still stored.
  - STOPPED holds STORE_O=0 until reset or a mode change.
- TRG_EVENT_O and OVERFLOW_O clear only on reset or a mode change.
- Stream mode:
  - S_REQ: LOAD_REQUEST_O=1 for one cycle, then S_WAIT.
  - S_WAIT: on LOAD_GRANT_I, shift <= DATA_I and go to S_DRAIN.
  - S_DRAIN:
    - STREAM_VALID_O=1 and STREAM_O[L-1:0] = shift[pos+L-1:pos], upper bits 0.
    - On VALID&&READY, pos += L.
    - When pos+L == WIDTH at the handshake, go to S_REQ.
    - STREAM_O is stable while VALID && !READY.
  - LOAD_GRANT_I outside S_WAIT is ignored.
- Reset asserted mid-operation clears all state immediately (asynchronous).

Optional Feature:
- Macro: TRACE_PACKER_PREFETCH_EN.
- Defined:
  - Adds a one-word prefetch buffer. The next LOAD_REQUEST_O is issued the cycle after the current word enters shift.
  - If the buffer is full when the last lane handshakes, the buffer moves into shift at that edge and STREAM_VALID_O stays high with no bubble.
  - Mode change also flushes the buffer.
- Undefined:
  - Strict REQ/WAIT/DRAIN sequence, giving a minimum 2-cycle gap between words.

Test Plan:
- WIDTH=32, NTRACE_I=3, STORE_PERM_I=1, valid beats with lanes 0x11, 0x22, 0x33, 0x44 -> next cycle DATA_O=0x44332211, STORE_O=1 for exactly one cycle.
- NTRACE_I=2, TRG_I on the third valid beat of a word, then TRG_I again later -> EVENT_POS_O=8, TRG_EVENT_O=1, values unchanged by the second trigger.
- STORE_PERM_I=0 on a completing beat -> STORE_O=0, OVERFLOW_O=1, the next word packs from bit 0 and stores normally once STORE_PERM_I=1.
- NTRACE_I=7 -> clamped to L=32; every valid beat produces STORE_O one cycle later with DATA_O=TRACE_I.
- MODE_I=1, NTRACE_I=4, grant with DATA_I=0xDEADBEEF, STREAM_READY_I=1:
  - STREAM_O=0xBEEF then 0xDEAD, then LOAD_REQUEST_O pulses;
  - with the macro defined there is no STREAM_VALID_O gap.
- RST_NI low mid-word, asynchronous to CLK_I -> all outputs 0 before the next edge; after release, capture restarts at fill 0.
